bcd2bin_seq: RTL and testbench



---
 rtl/bcd2bin_pkg.sv | 29 ++
 rtl/bcd2bin_lane.sv | 63 ++++++
 rtl/bcd2bin_seq.sv | 118 +++++++++++
 tb/tb_bcd2bin_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// rtl/bcd2bin_pkg.sv - shared calculator types and helpers for the BCD-to-binary converter
package bcd2bin_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    function automatic int slice_w(input int digits);
        return 4 * digits + 1;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Largest DIGITS-digit value must fit in the magnitude field.
    function automatic logic mag_w_fits(input int digits, input int mag_w);
        return (64'd1 << mag_w) > (pow10(digits) - 64'd1);
    endfunction

endpackage

// File: rtl/bcd2bin_lane.sv
// rtl/bcd2bin_lane.sv - one channel: x10 accumulate, invalid-digit flag, output formatting
module bcd2bin_lane
    import bcd2bin_pkg::*;
#(
    parameter int MAG_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic             last,
    input  logic [3:0]       digit,
    input  logic             sign,
    input  logic             twos,
    output logic [MAG_W:0]   bin,
    output logic             err
);

    logic [MAG_W-1:0] acc;
    logic [MAG_W-1:0] acc_n;
    logic             inval;
    logic             inval_n;
    logic [MAG_W:0]   fmt;

    always_comb begin
        acc_n   = (acc << 3) + (acc << 1) + MAG_W'(digit);
        inval_n = inval | (digit > BCD_DIGIT_MAX);
    end

    // Negative zero collapses to zero in both formats.
    always_comb begin
        fmt = '0;
        if (!inval_n && (acc_n != '0)) begin
            if (!twos) begin
                fmt = {sign, acc_n};
            end else if (sign) begin
                fmt = ~{1'b0, acc_n} + 1'b1;
            end else begin
                fmt = {1'b0, acc_n};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            inval <= 1'b0;
            bin   <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            inval <= 1'b0;
        end else if (step) begin
            acc   <= acc_n;
            inval <= inval_n;
            if (last) begin
                bin <= fmt;
                err <= inval_n;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - multi-channel sequential signed BCD-to-binary converter with handshake
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int MAG_W  = 17,
    parameter int CH     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           twos,
    input  logic [CH*slice_w(DIGITS)-1:0]  bcd_in,
    output logic                           busy,
    output logic                           done,
    output logic [CH*(MAG_W+1)-1:0]        bin_out,
    output logic [CH-1:0]                  err
);

    localparam int SW    = slice_w(DIGITS);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (!mag_w_fits(DIGITS, MAG_W)) begin : g_cfg_err
            $error("bcd2bin_seq: MAG_W too small to hold 10^DIGITS-1");
        end
    endgenerate

    state_t             state;
    state_t             state_n;
    logic               load;
    logic               step;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    logic [CH*SW-1:0]   bcd_q;
    logic               twos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(DIGITS - 1)) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            bcd_q  <= '0;
            twos_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_n == RUN);
            done <= last;
            if (load) begin
                cnt    <= '0;
                bcd_q  <= bcd_in;
                twos_q <= twos;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        logic [3:0] digit;

        // Digit select, MSD first: count k picks nibble DIGITS-1-k.
        always_comb begin
            digit = '0;
            for (int k = 0; k < DIGITS; k++) begin
                if (cnt == CNT_W'(k)) begin
                    digit = bcd_q[g*SW + 4*(DIGITS-1-k) +: 4];
                end
            end
        end

        bcd2bin_lane #(
            .MAG_W (MAG_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (load),
            .step  (step),
            .last  (last),
            .digit (digit),
            .sign  (bcd_q[g*SW + SW - 1]),
            .twos  (twos_q),
            .bin   (bin_out[g*(MAG_W+1) +: MAG_W+1]),
            .err   (err[g])
        );
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - randomized self-checking bench for bcd2bin_seq against an arithmetic model
module tb_bcd2bin_seq;

    localparam int DIGITS = 5;
    localparam int MAG_W  = 17;
    localparam int CH     = 2;
    localparam int SW     = 4 * DIGITS + 1;
    localparam int OW     = MAG_W + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               twos;
    logic [CH*SW-1:0]   bcd_in;
    logic               busy;
    logic               done;
    logic [CH*OW-1:0]   bin_out;
    logic [CH-1:0]      err;

    int checks = 0;
    int errors = 0;

    bcd2bin_seq #(
        .DIGITS (DIGITS),
        .MAG_W  (MAG_W),
        .CH     (CH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .twos    (twos),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: decimal value from digits, then the formatting rules.
    function automatic logic [OW-1:0] ref_bin(input logic [SW-1:0] s, input logic tw, output logic e);
        longint mag;
        logic   neg;
        logic [3:0] d;
        mag = 0;
        e   = 1'b0;
        neg = s[SW-1];
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = s[4*k +: 4];
            if (d > 4'd9) e = 1'b1;
            mag = mag * 10 + longint'(d);
        end
        if (e || mag == 0) return '0;
        if (tw) return neg ? OW'((longint'(1) << OW) - mag) : OW'(mag);
        return OW'((longint'(neg) << MAG_W) + mag);
    endfunction

    function automatic logic [SW-1:0] rand_op();
        logic [SW-1:0] s;
        s = '0;
        s[SW-1] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) != 0) begin
            for (int k = 0; k < DIGITS; k++) s[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 5) == 0) s[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return s;
    endfunction

    task automatic check_results(input string tag, input logic [CH*SW-1:0] ops, input logic tw);
        logic e;
        logic [OW-1:0] exp;
        for (int c = 0; c < CH; c++) begin
            exp = ref_bin(ops[c*SW +: SW], tw, e);
            chk({tag, "_bin"}, 64'(bin_out[c*OW +: OW]), 64'(exp));
            chk({tag, "_err"}, 64'(err[c]), 64'(e));
        end
    endtask

    // Full conversion with inputs scrambled and start toggled while busy.
    task automatic do_conv(input string tag, input logic [CH*SW-1:0] ops, input logic tw);
        @(negedge clk);
        bcd_in = ops;
        twos   = tw;
        start  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_done_early"}, 64'(done), 64'd0);
            start  = 1'($urandom_range(0, 1));
            bcd_in = {rand_op(), rand_op()};
            twos   = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        check_results(tag, ops, tw);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    logic [CH*SW-1:0] ops;
    logic             tw_r;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        twos   = 1'b0;
        bcd_in = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bin", 64'(bin_out), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_bin", 64'(bin_out), 64'd0);

        do_conv("sm", {1'b0, 20'h99999, 1'b1, 20'h12345}, 1'b0);
        do_conv("tc", {1'b0, 20'h99999, 1'b1, 20'h12345}, 1'b1);
        do_conv("zero_sm", {1'b0, 20'h1A000, 1'b1, 20'h00000}, 1'b0);
        do_conv("zero_tc", {1'b0, 20'h1A000, 1'b1, 20'h00000}, 1'b1);
        do_conv("max_tc", {1'b1, 20'h99999, 1'b0, 20'h00001}, 1'b1);

        for (int n = 0; n < 40; n++) begin
            do_conv("rnd", {rand_op(), rand_op()}, 1'($urandom_range(0, 1)));
        end

        // Start held high: done at E5, E11, E17.
        ops  = {rand_op(), rand_op()};
        tw_r = 1'($urandom_range(0, 1));
        @(negedge clk);
        bcd_in = ops;
        twos   = tw_r;
        start  = 1'b1;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            #1;
            chk("b2b_done", 64'(done), 64'((e == 5) || (e == 11) || (e == 17)));
            if (e == 5) check_results("b2b", ops, tw_r);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (DIGITS + 2) @(negedge clk);

        // Reset at E3 aborts; outputs cleared, no done afterwards.
        do_conv("pre_rst", {1'b0, 20'h54321, 1'b1, 20'h00777}, 1'b0);
        @(negedge clk);
        bcd_in = {1'b0, 20'h11111, 1'b0, 20'h22222};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("abort_bin", 64'(bin_out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        chk("abort_err", 64'(err), 64'd0);
        do_conv("post_rst", {1'b1, 20'h00042, 1'b0, 20'h31415}, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
